// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one 256-bit burst memory port among dcache, icache and prefetcher.
// Optional grant/busy performance counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned AGE_W        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   dc_addr,
  input  logic [31:0]   ic_addr,
  input  logic [31:0]   pf_addr,
  input  logic          dc_read,
  input  logic          dc_write,
  input  logic          ic_read,
  input  logic          pf_read,
  input  logic [255:0]  dc_wdata,
  output logic [255:0]  dc_rdata,
  output logic [255:0]  ic_rdata,
  output logic [255:0]  pf_rdata,
  output logic          dc_resp,
  output logic          ic_resp,
  output logic          pf_resp,
  output logic [31:0]   dfp_addr,
  output logic          dfp_read,
  output logic          dfp_write,
  output logic [255:0]  dfp_wdata,
  input  logic [255:0]  dfp_rdata,
  input  logic          dfp_resp
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_dc_grants,
  output logic [31:0]   perf_ic_grants,
  output logic [31:0]   perf_pf_grants,
  output logic [31:0]   perf_busy_cycles
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {GNT_DC = 2'd0, GNT_IC = 2'd1, GNT_PF = 2'd2} gnt_e;

  state_e           state_q;
  gnt_e             gnt_q;
  gnt_e             win;
  logic [31:0]      addr_q, addr_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic [255:0]     wdata_q, wdata_d;
  logic [AGE_W-1:0] ic_age_q, ic_age_d;
  logic [AGE_W-1:0] pf_age_q, pf_age_d;
  logic [255:0]     dc_rdata_q, ic_rdata_q, pf_rdata_q;
  logic             dc_req, any_req, ic_starved, pf_starved, resp_hit;

  always_comb begin
    dc_req     = dc_read | dc_write;
    any_req    = dc_req | ic_read | pf_read;
    ic_starved = 32'(ic_age_q) >= STARVE_LIMIT;
    pf_starved = 32'(pf_age_q) >= STARVE_LIMIT;

    win = GNT_PF;
    if (ic_read && ic_starved)      win = GNT_IC;
    else if (pf_read && pf_starved) win = GNT_PF;
    else if (dc_req)                win = GNT_DC;
    else if (ic_read)               win = GNT_IC;

    // A simultaneous dcache read+write is served as the write; the held read is re-arbitrated later.
    addr_d  = pf_addr;
    write_d = 1'b0;
    wdata_d = '0;
    case (win)
      GNT_DC: begin
        addr_d  = dc_addr;
        write_d = dc_write;
        wdata_d = dc_write ? dc_wdata : '0;
      end
      GNT_IC:  addr_d = ic_addr;
      default: addr_d = pf_addr;
    endcase
    read_d = ~write_d;

    ic_age_d = ic_age_q;
    pf_age_d = pf_age_q;
    if (state_q == IDLE) begin
      if (!ic_read || win == GNT_IC) ic_age_d = '0;
      else if (ic_age_q != '1)       ic_age_d = ic_age_q + AGE_W'(1);
      if (!pf_read || win == GNT_PF) pf_age_d = '0;
      else if (pf_age_q != '1)       pf_age_d = pf_age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_DC;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      ic_age_q   <= '0;
      pf_age_q   <= '0;
      dc_rdata_q <= '0;
      ic_rdata_q <= '0;
      pf_rdata_q <= '0;
    end else begin
      ic_age_q <= ic_age_d;
      pf_age_q <= pf_age_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= BUSY;
            gnt_q   <= win;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
          end
        end
        BUSY: begin
          if (dfp_resp) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            case (gnt_q)
              GNT_DC:  dc_rdata_q <= dfp_rdata;
              GNT_IC:  ic_rdata_q <= dfp_rdata;
              default: pf_rdata_q <= dfp_rdata;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_dc_q, perf_ic_q, perf_pf_q, perf_busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_dc_q   <= '0;
      perf_ic_q   <= '0;
      perf_pf_q   <= '0;
      perf_busy_q <= '0;
    end else begin
      if (state_q == BUSY) perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == IDLE && any_req) begin
        case (win)
          GNT_DC:  perf_dc_q <= perf_dc_q + 32'd1;
          GNT_IC:  perf_ic_q <= perf_ic_q + 32'd1;
          default: perf_pf_q <= perf_pf_q + 32'd1;
        endcase
      end
    end
  end

  assign perf_dc_grants   = perf_dc_q;
  assign perf_ic_grants   = perf_ic_q;
  assign perf_pf_grants   = perf_pf_q;
  assign perf_busy_cycles = perf_busy_q;
`endif

  assign resp_hit  = (state_q == BUSY) && dfp_resp;
  assign dc_resp   = resp_hit && (gnt_q == GNT_DC);
  assign ic_resp   = resp_hit && (gnt_q == GNT_IC);
  assign pf_resp   = resp_hit && (gnt_q == GNT_PF);
  assign dc_rdata  = dc_resp ? dfp_rdata : dc_rdata_q;
  assign ic_rdata  = ic_resp ? dfp_rdata : ic_rdata_q;
  assign pf_rdata  = pf_resp ? dfp_rdata : pf_rdata_q;
  assign dfp_addr  = addr_q;
  assign dfp_read  = read_q;
  assign dfp_write = write_q;
  assign dfp_wdata = wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256-bit burst memory port (dfp) among three requesters: dcache (read/write), icache (read) and prefetcher (read).
- Sits between the caches/prefetcher and the memory model/burst unit.
- Latches one granted request, replays it to memory and routes the response back to the granted requester only.
- Fixed priority dcache > icache > prefetch, with starvation promotion for the two lower requesters.

Parameters:
- STARVE_LIMIT, 8: consecutive lost arbitration decisions after which a pending icache/prefetch request is promoted; legal range 1..255.
- AGE_W, 8: width of each starvation age counter; must satisfy STARVE_LIMIT <= 2^AGE_W-1.

Ports:
- clk  in  1  sole clock; one clock; reset is asynchronous and active-low.
- rst  in  1  asynchronous, active-low reset.
- dc_addr, ic_addr, pf_addr  in  32 each  requester byte addresses, 32-byte aligned.
- dc_read, dc_write, ic_read, pf_read  in  1 each  request levels; each is held until that requester's resp.
- dc_wdata  in  256  dcache write line.
- dc_rdata, ic_rdata, pf_rdata  out  256 each  line returned to requester.
- dc_resp, ic_resp, pf_resp  out  1 each  one-cycle completion pulse.
- dfp_addr  out  32  memory address.
- dfp_read, dfp_write  out  1 each  memory request.
- dfp_wdata  out  256  memory write line.
- dfp_rdata  in  256  memory read line.
- dfp_resp  in  1  memory completion pulse.

Behaviour:
- FSM states: IDLE and BUSY.
- Reset values (asynchronous, rst=0):
  - state=IDLE; all age counters 0; latched request registers 0.
  - All dfp_* and *_resp outputs 0; *_rdata 0.
- Arbitration in IDLE, evaluated on each clk edge when any request is pending:
  - Winner order: starved icache, then starved prefetch, then dcache, then icache, then prefetch.
  - A requester is starved when its age counter >= STARVE_LIMIT.
  - On the edge: latch winner id, address, op and wdata into registers; go to BUSY.
  - Arbitration latency is exactly 1 cycle. dfp_read/dfp_write assert the cycle after the request is first seen; they are never combinational from requester inputs.
- Age counters:
  - At each IDLE decision, the counter of each pending non-winning icache/prefetch request increments, saturating at 2^AGE_W-1.
  - The winner's counter clears.
  - A counter clears whenever its request is low in IDLE.
- In BUSY:
  - dfp_addr, dfp_read, dfp_write and dfp_wdata are driven from the latched registers and held constant until dfp_resp.
  - Requester input changes are ignored.
- Response:
  - On dfp_resp in BUSY, the granted requester's resp pulses in that same cycle, with its rdata = dfp_rdata (combinational pass).
  - Other requesters' resp stay 0 and their rdata hold their last value.
  - Next state is IDLE; dfp_read/dfp_write deassert the following cycle.
- Back-to-back: a held request is re-arbitrated in the IDLE cycle after resp. Minimum gap between two dfp requests is 1 idle cycle.
- dc_read and dc_write both high: treated as write; the read is re-arbitrated after completion.
- dfp_resp in IDLE: ignored; no resp pulse, no state change.
- Requester drops its request mid-BUSY: the transaction completes; the resp pulse is still issued to that requester.
- Reset asserted mid-BUSY: immediate return to IDLE with all outputs 0; the in-flight memory response after reset release is ignored.
- Address is passed unmodified; there is no alignment masking.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_dc_grants, perf_ic_grants, perf_pf_grants (32 each): wrapping count of grants per requester.
  - Adds perf_busy_cycles (32): cycles spent in BUSY.
  - All counters reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read: ic_read=1, ic_addr=0x0000_1020, memory responds 4 cycles after dfp_read -> dfp_read=1 with dfp_addr=0x0000_1020 on cycle 1; ic_resp pulses with ic_rdata=dfp_rdata; dc_resp and pf_resp stay 0.
- Priority: dc_write (0x2000, wdata all 0xA5) and pf_read (0x3000) raised in the same cycle -> dcache write issued first with dfp_write=1 and dfp_wdata=0xA5..; prefetch read 0x3000 issued 1 idle cycle after dc_resp.
- Starvation: dcache requests continuously, pf_read held, STARVE_LIMIT=2 -> prefetch granted on the 3rd decision; its age counter clears afterward.
- Stability: during BUSY, ic_addr changes 0x1000 -> 0x5000 -> dfp_addr stays 0x1000 until dfp_resp.
- Reset mid-transaction: rst=0 while BUSY -> next cycle all dfp_* and *_resp are 0, state=IDLE; a stray dfp_resp after release produces no resp pulse.
- With MEM_ARB_PERF_CNT_EN: 3 icache and 2 dcache transactions -> perf_ic_grants=3, perf_dc_grants=2, perf_pf_grants=0.
